word_write_coalescer: RTL and testbench
=======================================

WORD_WRITE_COALESCER -- requirements
Module: word_write_coalescer

Interface
REQ-001 Parameter WORD_ADDR_WIDTH, default 4, SHALL set the word address width (16 words, 64 bytes).
REQ-002 Parameter TIMEOUT_CYCLES, default 15, SHALL set the number of idle PENDING cycles before auto-commit; legal range 1..255.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 in_valid  input  1  SHALL mark an upstream byte-lane write request.
REQ-006 in_ready  output  1  SHALL indicate that the request is accepted this cycle; transfer occurs when in_valid and in_ready are both 1.
REQ-007 in_word_addr  input  WORD_ADDR_WIDTH  SHALL carry the target word address.
REQ-008 in_byte_en  input  4  SHALL carry lane enables, bit i covering data[8i+7:8i].
REQ-009 in_data  input  32  SHALL carry lane-positioned write data.
REQ-010 flush_in  input  1  SHALL request immediate commit of any pending word.
REQ-011 mem_valid  output  1  SHALL mark a valid memory write.
REQ-012 mem_ready  input  1  SHALL complete a memory write when sampled high with mem_valid.
REQ-013 mem_addr / mem_byte_en / mem_data  output  WORD_ADDR_WIDTH / 4 / 32  SHALL carry the coalesced write.
REQ-014 busy_out  output  1  SHALL be high whenever state is not EMPTY.

Function
REQ-015 The block SHALL use three states: EMPTY, PENDING, COMMIT.
REQ-016 EMPTY: in_ready=1; on transfer, buffer SHALL load addr, byte_en and lane-masked data (disabled lanes zero), then go to PENDING.
REQ-017 PENDING: in_ready SHALL be 1 only when in_word_addr equals the buffered address (combinational compare).
REQ-018 PENDING merge: enabled lanes SHALL overwrite buffered lanes (latest write wins); buffered byte_en SHALL become the OR of old and new.
REQ-019 PENDING with in_valid=1 and a different address: no transfer; state SHALL go to COMMIT next cycle; the request stays stalled until re-accepted from EMPTY.
REQ-020 PENDING: if merged byte_en equals 4'b1111, state SHALL go to COMMIT next cycle.
REQ-021 PENDING: flush_in=1 SHALL send state to COMMIT next cycle; a same-cycle matching transfer SHALL be merged before commit.
REQ-022 Idle counter SHALL clear on entry to PENDING and on each merge, increment on every other PENDING cycle, and send state to COMMIT when it reaches TIMEOUT_CYCLES.
REQ-023 COMMIT: mem_valid=1, in_ready=0; mem_addr/byte_en/data SHALL be held stable until mem_ready=1, then state SHALL go to EMPTY.
REQ-024 mem_valid SHALL be 0 in EMPTY and PENDING; a write SHALL never be issued with mem_byte_en=0.
REQ-025 flush_in in EMPTY or COMMIT SHALL have no effect.
REQ-026 Latency: a full-word merge SHALL present mem_valid exactly 1 cycle after the completing transfer.

Reset
REQ-027 Asserting rst_n low SHALL immediately force EMPTY, idle counter 0, buffer addr/byte_en/data 0.
REQ-028 During reset: in_ready=0, mem_valid=0, mem_addr=0, mem_byte_en=0, mem_data=0, busy_out=0; in_ready SHALL rise in the first cycle after release.
REQ-029 Reset mid-COMMIT SHALL drop the pending write without completion.

Structure
REQ-030 Shared package coalescer_pkg SHALL hold the state enum, BYTE_EN_FULL=4'b1111, and default width/timeout constants.
REQ-031 Lane merging SHALL be a combinational sub-module byte_lane_merge (old data/en, new data/en -> merged data/en).
REQ-032 Upstream byte-to-word conversion is external; this block contains no byte-address decode.

Verification
REQ-033 Writes to word 3, lanes 0..3 with data 11,22,33,44 on consecutive cycles, mem_ready=1 -> one write: addr 3, en 1111, data 0x44332211, one cycle after last transfer.
REQ-034 Lane 1 = 0xAA to word 2, then lane 0 = 0x55 to word 5 -> first write addr 2, en 0010, data 0x0000AA00; in_ready low until EMPTY; then word 5 accepted.
REQ-035 Single lane-2 write 0x7E to word 0, no further input, TIMEOUT_CYCLES=15 -> mem_valid rises after 15 idle cycles, en 0100, data 0x007E0000.
REQ-036 Lane 0 written 0x01 then 0x02 to word 1, then flush_in -> write en 0001, data 0x00000002.
REQ-037 COMMIT with mem_ready low 5 cycles -> outputs stable all 5 cycles; in_ready=0; completes on 6th.
REQ-038 rst_n low during COMMIT -> mem_valid, busy_out 0 immediately; no write observed after release.

Source files
------------

// File: rtl/coalescer_pkg.sv
// Shared types and constants for the word write coalescer.
package coalescer_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_PENDING = 2'd1,
        ST_COMMIT  = 2'd2
    } state_t;

    localparam int unsigned LANES                   = 4;
    localparam int unsigned DATA_WIDTH              = 32;
    localparam logic [3:0]  BYTE_EN_FULL            = 4'b1111;
    localparam int unsigned DEFAULT_WORD_ADDR_WIDTH = 4;
    localparam int unsigned DEFAULT_TIMEOUT_CYCLES  = 15;
    localparam int unsigned IDLE_CNT_WIDTH          = 8;

endpackage

// File: rtl/byte_lane_merge.sv
// Combinational byte-lane merge: enabled new lanes replace old lanes, enables accumulate.
module byte_lane_merge
    import coalescer_pkg::*;
(
    input  logic [DATA_WIDTH-1:0] old_data,
    input  logic [LANES-1:0]      old_en,
    input  logic [DATA_WIDTH-1:0] new_data,
    input  logic [LANES-1:0]      new_en,
    output logic [DATA_WIDTH-1:0] merged_data,
    output logic [LANES-1:0]      merged_en
);

    always_comb begin
        merged_data = old_data;
        merged_en   = old_en | new_en;
        for (int unsigned i = 0; i < LANES; i++) begin
            if (new_en[i]) begin
                merged_data[8*i +: 8] = new_data[8*i +: 8];
            end
        end
    end

endmodule

// File: rtl/word_write_coalescer.sv
// Coalesces byte-lane writes to one word into a single memory write,
// committing on full word, address change, flush or idle timeout.
module word_write_coalescer
    import coalescer_pkg::*;
#(
    parameter int unsigned WORD_ADDR_WIDTH = DEFAULT_WORD_ADDR_WIDTH,
    parameter int unsigned TIMEOUT_CYCLES  = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WORD_ADDR_WIDTH-1:0] in_word_addr,
    input  logic [LANES-1:0]           in_byte_en,
    input  logic [DATA_WIDTH-1:0]      in_data,
    input  logic                       flush_in,
    output logic                       mem_valid,
    input  logic                       mem_ready,
    output logic [WORD_ADDR_WIDTH-1:0] mem_addr,
    output logic [LANES-1:0]           mem_byte_en,
    output logic [DATA_WIDTH-1:0]      mem_data,
    output logic                       busy_out
);

    state_t                      state;
    state_t                      next_state;
    logic [WORD_ADDR_WIDTH-1:0]  buf_addr;
    logic [LANES-1:0]            buf_en;
    logic [DATA_WIDTH-1:0]       buf_data;
    logic [IDLE_CNT_WIDTH-1:0]   idle_cnt;

    logic                        addr_match;
    logic                        xfer;
    logic                        idle_expire;
    logic [DATA_WIDTH-1:0]       merge_old_data;
    logic [LANES-1:0]            merge_old_en;
    logic [LANES-1:0]            merge_new_en;
    logic [DATA_WIDTH-1:0]       merged_data;
    logic [LANES-1:0]            merged_en;

    assign addr_match = (in_word_addr == buf_addr);
    assign xfer       = in_valid & in_ready;

    // From EMPTY the merge starts from a zero word, which masks disabled lanes on load.
    assign merge_old_data = (state == ST_PENDING) ? buf_data : '0;
    assign merge_old_en   = (state == ST_PENDING) ? buf_en   : '0;
    assign merge_new_en   = xfer ? in_byte_en : '0;

    assign idle_expire = ({1'b0, idle_cnt} + 9'd1) == 9'(TIMEOUT_CYCLES);

    byte_lane_merge u_merge (
        .old_data    (merge_old_data),
        .old_en      (merge_old_en),
        .new_data    (in_data),
        .new_en      (merge_new_en),
        .merged_data (merged_data),
        .merged_en   (merged_en)
    );

    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        unique case (state)
            ST_EMPTY: begin
                in_ready = rst_n;
                // A zero-enable request is consumed but never buffered, so no empty write can issue.
                if (xfer && (in_byte_en != '0)) begin
                    next_state = ST_PENDING;
                end
            end
            ST_PENDING: begin
                in_ready = addr_match;
                if ((merged_en == BYTE_EN_FULL) || flush_in ||
                    (in_valid && !addr_match) || (!xfer && idle_expire)) begin
                    next_state = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                if (mem_ready) begin
                    next_state = ST_EMPTY;
                end
            end
            default: next_state = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_EMPTY;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_addr <= '0;
            buf_en   <= '0;
            buf_data <= '0;
            idle_cnt <= '0;
        end else begin
            unique case (state)
                ST_EMPTY: begin
                    idle_cnt <= '0;
                    if (xfer && (in_byte_en != '0)) begin
                        buf_addr <= in_word_addr;
                        buf_en   <= merged_en;
                        buf_data <= merged_data;
                    end
                end
                ST_PENDING: begin
                    if (xfer) begin
                        buf_en   <= merged_en;
                        buf_data <= merged_data;
                        idle_cnt <= '0;
                    end else begin
                        idle_cnt <= idle_cnt + 1'b1;
                    end
                end
                default: begin
                    idle_cnt <= '0;
                end
            endcase
        end
    end

    assign mem_valid   = (state == ST_COMMIT);
    assign mem_addr    = buf_addr;
    assign mem_byte_en = buf_en;
    assign mem_data    = buf_data;
    assign busy_out    = (state != ST_EMPTY);

endmodule

// File: tb/tb_word_write_coalescer.sv
// Randomized and directed bench for word_write_coalescer against a behavioural buffer model.
module tb_word_write_coalescer;

    localparam int unsigned AW = 4;
    localparam int unsigned TO = 15;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [AW-1:0] in_word_addr;
    logic [3:0]    in_byte_en;
    logic [31:0]   in_data;
    logic          flush_in;
    logic          mem_valid;
    logic          mem_ready;
    logic [AW-1:0] mem_addr;
    logic [3:0]    mem_byte_en;
    logic [31:0]   mem_data;
    logic          busy_out;

    int checks   = 0;
    int failures = 0;

    // Model: a buffered word (if any) and whether it is being offered to memory.
    bit          m_pend;
    bit          m_commit;
    logic [3:0]  m_addr;
    logic [3:0]  m_en;
    logic [31:0] m_data;
    int          m_idle;

    word_write_coalescer #(
        .WORD_ADDR_WIDTH (AW),
        .TIMEOUT_CYCLES  (TO)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_word_addr (in_word_addr),
        .in_byte_en   (in_byte_en),
        .in_data      (in_data),
        .flush_in     (flush_in),
        .mem_valid    (mem_valid),
        .mem_ready    (mem_ready),
        .mem_addr     (mem_addr),
        .mem_byte_en  (mem_byte_en),
        .mem_data     (mem_data),
        .busy_out     (busy_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pend   = 1'b0;
        m_commit = 1'b0;
        m_addr   = '0;
        m_en     = '0;
        m_data   = '0;
        m_idle   = 0;
    endtask

    // Called just after a rising edge; drives one cycle, checks, advances the model.
    task automatic cycle(input bit v, input logic [3:0] a, input logic [3:0] e,
                         input logic [31:0] d, input bit f, input bit r);
        bit exp_ready;
        bit hit;
        in_valid     = v;
        in_word_addr = a;
        in_byte_en   = e;
        in_data      = d;
        flush_in     = f;
        mem_ready    = r;
        #3;
        exp_ready = !m_commit && (!m_pend || (a == m_addr));
        check("in_ready", in_ready, exp_ready);
        check("mem_valid", mem_valid, m_commit);
        check("busy_out", busy_out, m_pend || m_commit);
        if (m_commit) begin
            check("mem_addr", mem_addr, m_addr);
            check("mem_byte_en", mem_byte_en, m_en);
            check("mem_data", mem_data, m_data);
        end
        if (m_commit) begin
            if (r) m_commit = 1'b0;
        end else if (m_pend) begin
            hit = v && (a == m_addr);
            if (hit) begin
                for (int i = 0; i < 4; i++) begin
                    if (e[i]) begin
                        m_data[8*i +: 8] = d[8*i +: 8];
                        m_en[i] = 1'b1;
                    end
                end
                m_idle = 0;
            end else begin
                m_idle = m_idle + 1;
            end
            if (f || (m_en == 4'hF) || (v && !hit) || (!hit && m_idle == TO)) begin
                m_pend   = 1'b0;
                m_commit = 1'b1;
            end
        end else if (v && (e != 4'h0)) begin
            m_data = '0;
            for (int i = 0; i < 4; i++) begin
                if (e[i]) m_data[8*i +: 8] = d[8*i +: 8];
            end
            m_en   = e;
            m_addr = a;
            m_pend = 1'b1;
            m_idle = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input bit r);
        for (int i = 0; i < n; i++) cycle(1'b0, 4'h0, 4'h0, 32'h0, 1'b0, r);
    endtask

    initial begin
        rst_n        = 1'b0;
        in_valid     = 1'b0;
        in_word_addr = '0;
        in_byte_en   = '0;
        in_data      = '0;
        flush_in     = 1'b0;
        mem_ready    = 1'b0;
        model_reset();
        #2;
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_mem_valid", mem_valid, 1'b0);
        check("rst_busy", busy_out, 1'b0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_mem_en", mem_byte_en, 32'h0);
        check("rst_mem_data", mem_data, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check("release_in_ready", in_ready, 1'b1);
        @(posedge clk);
        #1;

        // Four lanes of word 3 merge into one full write one cycle after the last.
        cycle(1'b1, 4'h3, 4'b0001, 32'h0000_0011, 1'b0, 1'b1);
        cycle(1'b1, 4'h3, 4'b0010, 32'h0000_2200, 1'b0, 1'b1);
        cycle(1'b1, 4'h3, 4'b0100, 32'h0033_0000, 1'b0, 1'b1);
        cycle(1'b1, 4'h3, 4'b1000, 32'h4400_0000, 1'b0, 1'b1);
        check("full_valid", mem_valid, 1'b1);
        check("full_addr", mem_addr, 32'h3);
        check("full_en", mem_byte_en, 32'hF);
        check("full_data", mem_data, 32'h4433_2211);
        idle(2, 1'b1);

        // Address change forces commit; stalled request accepted from EMPTY.
        cycle(1'b1, 4'h2, 4'b0010, 32'h0000_AA00, 1'b0, 1'b1);
        cycle(1'b1, 4'h5, 4'b0001, 32'h0000_0055, 1'b0, 1'b1);
        check("chg_valid", mem_valid, 1'b1);
        check("chg_addr", mem_addr, 32'h2);
        check("chg_en", mem_byte_en, 32'h2);
        check("chg_data", mem_data, 32'h0000_AA00);
        cycle(1'b1, 4'h5, 4'b0001, 32'h0000_0055, 1'b0, 1'b1);
        cycle(1'b1, 4'h5, 4'b0001, 32'h0000_0055, 1'b0, 1'b1);
        check("chg_busy_w5", busy_out, 1'b1);
        cycle(1'b0, 4'h0, 4'h0, 32'h0, 1'b1, 1'b1);
        check("chg_w5_addr", mem_addr, 32'h5);
        check("chg_w5_data", mem_data, 32'h0000_0055);
        idle(2, 1'b1);

        // Idle timeout, then a memory stall of five cycles.
        cycle(1'b1, 4'h0, 4'b0100, 32'h007E_0000, 1'b0, 1'b0);
        idle(TO - 1, 1'b0);
        check("to_not_yet", mem_valid, 1'b0);
        idle(1, 1'b0);
        check("to_valid", mem_valid, 1'b1);
        check("to_en", mem_byte_en, 32'h4);
        check("to_data", mem_data, 32'h007E_0000);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 4'h9, 4'hF, 32'h1234_5678, 1'b1, 1'b0);
            check("stall_valid", mem_valid, 1'b1);
            check("stall_data", mem_data, 32'h007E_0000);
        end
        cycle(1'b0, 4'h0, 4'h0, 32'h0, 1'b0, 1'b1);
        check("stall_done", busy_out, 1'b0);

        // Latest write wins, flush commits.
        cycle(1'b1, 4'h1, 4'b0001, 32'h0000_0001, 1'b0, 1'b1);
        cycle(1'b1, 4'h1, 4'b0001, 32'h0000_0002, 1'b0, 1'b1);
        cycle(1'b0, 4'h0, 4'h0, 32'h0, 1'b1, 1'b1);
        check("flush_en", mem_byte_en, 32'h1);
        check("flush_data", mem_data, 32'h0000_0002);
        idle(1, 1'b1);
        cycle(1'b0, 4'h0, 4'h0, 32'h0, 1'b1, 1'b1);
        check("flush_empty", busy_out, 1'b0);

        // Reset during COMMIT drops the write.
        cycle(1'b1, 4'h6, 4'hF, 32'hDEAD_BEEF, 1'b0, 1'b0);
        idle(1, 1'b0);
        check("rc_valid", mem_valid, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rc_mem_valid", mem_valid, 1'b0);
        check("rc_busy", busy_out, 1'b0);
        check("rc_in_ready", in_ready, 1'b0);
        check("rc_mem_data", mem_data, 32'h0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(4, 1'b1);

        for (int n = 0; n < 1500; n++) begin
            cycle(($urandom_range(0, 9) < 6), 4'($urandom_range(0, 3)), 4'($urandom),
                  $urandom, ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) < 7));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
